// File: rtl/ring_requester_if.sv
`default_nettype none
// ============================================================================
//  Module      : ring_requester_if
//  Description : Core-side request and write-data handshake for the ring
//                requester.
//                  req_valid / req_addr / req_ready : one cache-line request
//                  wd_data / wd_empty / wd_rd       : FWFT write-data FIFO head
//                master : the core / FIFO side (drives request and FIFO head)
//                slave  : the ring requester (drives req_ready and wd_rd)
//  Revision    : 1.0  initial release
// ============================================================================
interface ring_requester_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic [31:0] wd_data;
    logic        wd_empty;
    logic        wd_rd;

    modport master (
        output req_valid,
        output req_addr,
        output wd_data,
        output wd_empty,
        input  req_ready,
        input  wd_rd
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  wd_data,
        input  wd_empty,
        output req_ready,
        output wd_rd
    );
endinterface
`default_nettype wire

// File: rtl/ring_requester.sv
`default_nettype none
// ============================================================================
//  Module      : ring_requester
//  Description : Per-core slot-ring injection stage. Waits for the Token,
//                raises its train count, lets the existing train pass, then
//                appends one Address slot and (for writes) LINE_WORDS
//                WriteData slots. Every other slot is forwarded with exactly
//                one cycle of registered latency.
//  Ports       : clock, reset                  clock / sync active-high reset
//                whichCore                     node number for injected slots
//                RingIn, SlotTypeIn, SourceIn  upstream slot
//                RingOut, SlotTypeOut, SourceOut registered downstream slot
//                req_if (slave)                request + write-data handshake
//                train_err                     sticky protocol error flag
//                tokens_seen, reqs_sent        optional statistics
//  Options     : define RING_REQ_STATS_EN to build the saturating statistics
//                counters; otherwise both statistics outputs read 0.
//  Revision    : 1.0  initial release
// ============================================================================
module ring_requester #(
    parameter int LINE_WORDS = 8,
    parameter int MAX_TRAIN  = 64,
    parameter int CNT_W      = 16
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic [3:0]       whichCore,
    input  wire logic [31:0]      RingIn,
    input  wire logic [3:0]       SlotTypeIn,
    input  wire logic [3:0]       SourceIn,
    output logic      [31:0]      RingOut,
    output logic      [3:0]       SlotTypeOut,
    output logic      [3:0]       SourceOut,
    ring_requester_if.slave       req_if,
    output logic                  train_err,
    output logic      [CNT_W-1:0] tokens_seen,
    output logic      [CNT_W-1:0] reqs_sent
);

    localparam logic [3:0] c_SLOT_TOKEN = 4'd1;
    localparam logic [3:0] c_SLOT_ADDR  = 4'd2;
    localparam logic [3:0] c_SLOT_WDATA = 4'd3;
    localparam logic [3:0] c_SLOT_NULL  = 4'd7;

    localparam int REM_W  = $clog2(MAX_TRAIN + 1);
    localparam int WORD_W = $clog2(LINE_WORDS + 1);

    typedef enum logic [1:0] {
        ST_PASS_ALL = 2'd0,
        ST_SKIP     = 2'd1,
        ST_APPEND   = 2'd2
    } state_t;

    state_t            r_state;
    logic [31:0]       r_ring_out;
    logic [3:0]        r_type_out;
    logic [3:0]        r_src_out;
    logic              r_req_ready;
    logic              r_train_err;
    logic [31:0]       r_addr;
    logic              r_is_read;
    logic [REM_W-1:0]  r_remaining;
    // 0 = Address slot, 1..LINE_WORDS = WriteData slot index
    logic [WORD_W-1:0] r_word;

    logic        w_is_token;
    logic        w_is_read;
    logic [31:0] w_k;
    logic [31:0] w_sum;
    logic        w_inject;
    logic        w_data_cycle;

    assign w_is_token = (SlotTypeIn == c_SLOT_TOKEN);
    assign w_is_read  = req_if.req_addr[28];
    assign w_k        = w_is_read ? 32'd1 : 32'(1 + LINE_WORDS);
    assign w_sum      = RingIn + w_k;

    // The RingIn bound keeps a huge (corrupt) count from wrapping w_sum
    // back under MAX_TRAIN.
    assign w_inject = (r_state == ST_PASS_ALL) && w_is_token
                   && req_if.req_valid
                   && (w_is_read || !req_if.wd_empty)
                   && (RingIn <= 32'(MAX_TRAIN))
                   && (w_sum  <= 32'(MAX_TRAIN));

    assign w_data_cycle = (r_state == ST_APPEND) && (r_word != '0);

    // Pop in the same cycle the FIFO head is captured into RingOut.
    assign req_if.wd_rd     = w_data_cycle && !req_if.wd_empty;
    assign req_if.req_ready = r_req_ready;

    assign RingOut     = r_ring_out;
    assign SlotTypeOut = r_type_out;
    assign SourceOut   = r_src_out;
    assign train_err   = r_train_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_PASS_ALL;
            r_ring_out  <= '0;
            r_type_out  <= c_SLOT_NULL;
            r_src_out   <= '0;
            r_req_ready <= 1'b0;
            r_train_err <= 1'b0;
            r_addr      <= '0;
            r_is_read   <= 1'b0;
            r_remaining <= '0;
            r_word      <= '0;
        end else begin
            r_req_ready <= 1'b0;
            case (r_state)
                ST_PASS_ALL: begin
                    r_ring_out <= RingIn;
                    r_type_out <= SlotTypeIn;
                    r_src_out  <= SourceIn;
                    if (w_inject) begin
                        r_ring_out  <= w_sum;
                        r_addr      <= req_if.req_addr;
                        r_is_read   <= w_is_read;
                        r_req_ready <= 1'b1;
                        r_word      <= '0;
                        if (RingIn == 32'd0) begin
                            r_state <= ST_APPEND;
                        end else begin
                            r_remaining <= RingIn[REM_W-1:0];
                            r_state     <= ST_SKIP;
                        end
                    end
                end

                ST_SKIP: begin
                    r_ring_out  <= RingIn;
                    r_type_out  <= SlotTypeIn;
                    r_src_out   <= SourceIn;
                    r_remaining <= r_remaining - REM_W'(1);
                    // A second Token inside our own train means the ring is broken.
                    if (w_is_token) begin
                        r_train_err <= 1'b1;
                    end
                    if (r_remaining == REM_W'(1)) begin
                        r_state <= ST_APPEND;
                    end
                end

                ST_APPEND: begin
                    // Incoming slot is overwritten; anything but Null is lost data.
                    if (SlotTypeIn != c_SLOT_NULL) begin
                        r_train_err <= 1'b1;
                    end
                    r_src_out <= whichCore;
                    if (r_word == '0) begin
                        r_ring_out <= r_addr;
                        r_type_out <= c_SLOT_ADDR;
                        if (r_is_read) begin
                            r_state <= ST_PASS_ALL;
                        end else begin
                            r_word <= WORD_W'(1);
                        end
                    end else begin
                        r_type_out <= c_SLOT_WDATA;
                        // Ring timing is fixed: an underrun emits 0 instead of stalling.
                        if (req_if.wd_empty) begin
                            r_ring_out  <= '0;
                            r_train_err <= 1'b1;
                        end else begin
                            r_ring_out <= req_if.wd_data;
                        end
                        if (r_word == WORD_W'(LINE_WORDS)) begin
                            r_state <= ST_PASS_ALL;
                        end else begin
                            r_word <= r_word + WORD_W'(1);
                        end
                    end
                end

                default: begin
                    r_state    <= ST_PASS_ALL;
                    r_ring_out <= '0;
                    r_type_out <= c_SLOT_NULL;
                    r_src_out  <= '0;
                end
            endcase
        end
    end

`ifdef RING_REQ_STATS_EN
    logic [CNT_W-1:0] r_tokens_seen;
    logic [CNT_W-1:0] r_reqs_sent;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tokens_seen <= '0;
            r_reqs_sent   <= '0;
        end else begin
            if ((r_state == ST_PASS_ALL) && w_is_token && (r_tokens_seen != '1)) begin
                r_tokens_seen <= r_tokens_seen + CNT_W'(1);
            end
            // w_inject is exactly the condition that raises req_ready next cycle.
            if (w_inject && (r_reqs_sent != '1)) begin
                r_reqs_sent <= r_reqs_sent + CNT_W'(1);
            end
        end
    end

    assign tokens_seen = r_tokens_seen;
    assign reqs_sent   = r_reqs_sent;
`else
    assign tokens_seen = '0;
    assign reqs_sent   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ring_requester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_requester
//  Description : Directed self-checking bench for ring_requester. Inputs are
//                driven and outputs sampled on the falling clock edge; a small
//                array models the first-word-fall-through write-data FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ring_requester;

    localparam logic [3:0] T_TOKEN = 4'd1;
    localparam logic [3:0] T_ADDR  = 4'd2;
    localparam logic [3:0] T_WDATA = 4'd3;
    localparam logic [3:0] T_NULL  = 4'd7;

`ifdef RING_REQ_STATS_EN
    localparam int EXP_TOK  = 5;
    localparam int EXP_REQS = 2;
`else
    localparam int EXP_TOK  = 0;
    localparam int EXP_REQS = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  whichCore = 4'd3;
    logic [31:0] RingIn = '0;
    logic [3:0]  SlotTypeIn = T_NULL;
    logic [3:0]  SourceIn = '0;
    logic [31:0] RingOut;
    logic [3:0]  SlotTypeOut;
    logic [3:0]  SourceOut;
    logic        train_err;
    logic [15:0] tokens_seen;
    logic [15:0] reqs_sent;

    int checks   = 0;
    int failures = 0;

    // FIFO model: wr_ptr is written by the stimulus, rd_ptr only by the pop process.
    logic [31:0] fifo_mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        force_empty = 1'b0;
    logic        wd_rd_s;

    ring_requester_if rif ();

    assign rif.wd_empty = force_empty || (rd_ptr == wr_ptr);
    assign rif.wd_data  = fifo_mem[rd_ptr[5:0]];

    always @(posedge clock) begin
        if (rif.wd_rd) rd_ptr <= rd_ptr + 1;
    end

    always #5 clock = ~clock;

    ring_requester #(.LINE_WORDS(8), .MAX_TRAIN(64), .CNT_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .whichCore  (whichCore),
        .RingIn     (RingIn),
        .SlotTypeIn (SlotTypeIn),
        .SourceIn   (SourceIn),
        .RingOut    (RingOut),
        .SlotTypeOut(SlotTypeOut),
        .SourceOut  (SourceOut),
        .req_if     (rif),
        .train_err  (train_err),
        .tokens_seen(tokens_seen),
        .reqs_sent  (reqs_sent)
    );

    // One ring cycle: present a slot, capture combinational wd_rd, then stop at
    // the next falling edge where the registered result of that slot is visible.
    task automatic cyc(input logic [3:0] t, input logic [31:0] d, input logic [3:0] s);
        SlotTypeIn = t;
        RingIn     = d;
        SourceIn   = s;
        #1;
        wd_rd_s = rif.wd_rd;
        @(negedge clock);
    endtask

    task automatic push(input logic [31:0] v);
        fifo_mem[wr_ptr[5:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(T_NULL, 32'd0, 4'd0);
        cyc(T_NULL, 32'd0, 4'd0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rif.req_valid = 1'b0;
        rif.req_addr  = 32'h0;
        cyc(T_ADDR, 32'h1234_5678, 4'd9);
        cyc(T_ADDR, 32'h1234_5678, 4'd9);
        checks++; if (RingOut !== 32'd0) begin failures++; $display("FAIL reset_ringout got=%h exp=0", RingOut); end
        checks++; if (SlotTypeOut !== T_NULL) begin failures++; $display("FAIL reset_type got=%0d exp=7", SlotTypeOut); end
        checks++; if (SourceOut !== 4'd0) begin failures++; $display("FAIL reset_source got=%0d exp=0", SourceOut); end
        checks++; if (rif.req_ready !== 1'b0 || wd_rd_s !== 1'b0) begin failures++; $display("FAIL reset_handshake ready=%b wd_rd=%b exp=0,0", rif.req_ready, wd_rd_s); end
        checks++; if (train_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", train_err); end
        checks++; if (tokens_seen !== 16'd0 || reqs_sent !== 16'd0) begin failures++; $display("FAIL reset_counters tok=%0d req=%0d exp=0,0", tokens_seen, reqs_sent); end
        reset = 1'b0;
    endtask

    task automatic test_idle_passthrough();
        cyc(T_ADDR, 32'h1000_0040, 4'd2);
        checks++; if ({SlotTypeOut, SourceOut, RingOut} !== {T_ADDR, 4'd2, 32'h1000_0040}) begin failures++; $display("FAIL idle_pass got=%0d/%0d/%h exp=2/2/10000040", SlotTypeOut, SourceOut, RingOut); end
        checks++; if (rif.req_ready !== 1'b0) begin failures++; $display("FAIL idle_ready got=%b exp=0", rif.req_ready); end
        cyc(T_NULL, 32'd0, 4'd0);
        checks++; if ({SlotTypeOut, RingOut} !== {T_NULL, 32'd0}) begin failures++; $display("FAIL idle_latency got=%0d/%h exp=7/0", SlotTypeOut, RingOut); end
    endtask

    task automatic test_read_empty_train();
        whichCore     = 4'd3;
        rif.req_addr  = 32'h1000_0010;
        rif.req_valid = 1'b1;
        cyc(T_TOKEN, 32'd0, 4'd5);
        checks++; if ({SlotTypeOut, SourceOut, RingOut} !== {T_TOKEN, 4'd5, 32'd1}) begin failures++; $display("FAIL read_token got=%0d/%0d/%0d exp=1/5/1", SlotTypeOut, SourceOut, RingOut); end
        checks++; if (rif.req_ready !== 1'b1) begin failures++; $display("FAIL read_ready got=%b exp=1", rif.req_ready); end
        rif.req_valid = 1'b0;
        rif.req_addr  = 32'hFFFF_FFFF;
        cyc(T_NULL, 32'd0, 4'd0);
        checks++; if ({SlotTypeOut, SourceOut, RingOut} !== {T_ADDR, 4'd3, 32'h1000_0010}) begin failures++; $display("FAIL read_addr got=%0d/%0d/%h exp=2/3/10000010", SlotTypeOut, SourceOut, RingOut); end
        checks++; if (rif.req_ready !== 1'b0) begin failures++; $display("FAIL read_ready_pulse got=%b exp=0", rif.req_ready); end
        cyc(T_ADDR, 32'h0000_0055, 4'd4);
        checks++; if ({SlotTypeOut, SourceOut, RingOut} !== {T_ADDR, 4'd4, 32'h55}) begin failures++; $display("FAIL read_back_pass got=%0d/%0d/%h exp=2/4/55", SlotTypeOut, SourceOut, RingOut); end
    endtask

    task automatic test_write_behind_train();
        int rd_cnt;
        for (int i = 0; i < 8; i++) push(32'hA0 + i);
        rif.req_addr  = 32'h0000_0020;
        rif.req_valid = 1'b1;
        cyc(T_TOKEN, 32'd2, 4'd6);
        checks++; if ({SlotTypeOut, RingOut} !== {T_TOKEN, 32'd11} || rif.req_ready !== 1'b1) begin failures++; $display("FAIL write_token got=%0d/%0d rdy=%b exp=1/11 rdy=1", SlotTypeOut, RingOut, rif.req_ready); end
        rif.req_valid = 1'b0;
        cyc(T_ADDR, 32'h111, 4'd1);
        checks++; if ({SlotTypeOut, SourceOut, RingOut} !== {T_ADDR, 4'd1, 32'h111}) begin failures++; $display("FAIL write_train1 got=%0d/%0d/%h exp=2/1/111", SlotTypeOut, SourceOut, RingOut); end
        cyc(T_ADDR, 32'h222, 4'd2);
        checks++; if ({SlotTypeOut, SourceOut, RingOut} !== {T_ADDR, 4'd2, 32'h222}) begin failures++; $display("FAIL write_train2 got=%0d/%0d/%h exp=2/2/222", SlotTypeOut, SourceOut, RingOut); end
        cyc(T_NULL, 32'd0, 4'd0);
        checks++; if ({SlotTypeOut, SourceOut, RingOut} !== {T_ADDR, 4'd3, 32'h20}) begin failures++; $display("FAIL write_addr got=%0d/%0d/%h exp=2/3/20", SlotTypeOut, SourceOut, RingOut); end
        rd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(T_NULL, 32'd0, 4'd0);
            if (wd_rd_s === 1'b1) rd_cnt++;
            checks++; if ({SlotTypeOut, SourceOut, RingOut} !== {T_WDATA, 4'd3, 32'hA0 + 32'(i)}) begin failures++; $display("FAIL write_data%0d got=%0d/%0d/%h exp=3/3/%h", i, SlotTypeOut, SourceOut, RingOut, 32'hA0 + 32'(i)); end
        end
        checks++; if (rd_cnt !== 8) begin failures++; $display("FAIL write_wd_rd_count got=%0d exp=8", rd_cnt); end
        cyc(T_ADDR, 32'h77, 4'd1);
        checks++; if ({SlotTypeOut, RingOut} !== {T_ADDR, 32'h77} || wd_rd_s !== 1'b0) begin failures++; $display("FAIL write_after got=%0d/%h wd_rd=%b exp=2/77 wd_rd=0", SlotTypeOut, RingOut, wd_rd_s); end
        checks++; if (train_err !== 1'b0) begin failures++; $display("FAIL write_no_err got=%b exp=0", train_err); end
    endtask

    task automatic test_max_train();
        for (int i = 0; i < 8; i++) push(32'hB0 + i);
        rif.req_addr  = 32'h0000_0040;
        rif.req_valid = 1'b1;
        cyc(T_TOKEN, 32'd60, 4'd1);
        checks++; if ({SlotTypeOut, RingOut} !== {T_TOKEN, 32'd60} || rif.req_ready !== 1'b0) begin failures++; $display("FAIL max_reject got=%0d/%0d rdy=%b exp=1/60 rdy=0", SlotTypeOut, RingOut, rif.req_ready); end
        cyc(T_NULL, 32'd0, 4'd0);
        cyc(T_TOKEN, 32'd0, 4'd1);
        checks++; if ({SlotTypeOut, RingOut} !== {T_TOKEN, 32'd9} || rif.req_ready !== 1'b1) begin failures++; $display("FAIL max_retry got=%0d/%0d rdy=%b exp=1/9 rdy=1", SlotTypeOut, RingOut, rif.req_ready); end
        rif.req_valid = 1'b0;
        cyc(T_NULL, 32'd0, 4'd0);
        checks++; if ({SlotTypeOut, RingOut} !== {T_ADDR, 32'h40}) begin failures++; $display("FAIL max_addr got=%0d/%h exp=2/40", SlotTypeOut, RingOut); end
        for (int i = 0; i < 8; i++) cyc(T_NULL, 32'd0, 4'd0);
        checks++; if ({SlotTypeOut, RingOut} !== {T_WDATA, 32'hB7}) begin failures++; $display("FAIL max_last_data got=%0d/%h exp=3/b7", SlotTypeOut, RingOut); end
        // Read boundary: 64+1 exceeds the limit, 63+1 lands exactly on it.
        rif.req_addr  = 32'h1000_0200;
        rif.req_valid = 1'b1;
        cyc(T_TOKEN, 32'd64, 4'd1);
        checks++; if (RingOut !== 32'd64 || rif.req_ready !== 1'b0) begin failures++; $display("FAIL max_read64 got=%0d rdy=%b exp=64 rdy=0", RingOut, rif.req_ready); end
        cyc(T_TOKEN, 32'd63, 4'd1);
        checks++; if (RingOut !== 32'd64 || rif.req_ready !== 1'b1) begin failures++; $display("FAIL max_read63 got=%0d rdy=%b exp=64 rdy=1", RingOut, rif.req_ready); end
        rif.req_valid = 1'b0;
        for (int i = 0; i < 63; i++) cyc(T_ADDR, 32'd1000 + 32'(i), 4'd2);
        checks++; if ({SlotTypeOut, RingOut} !== {T_ADDR, 32'd1062}) begin failures++; $display("FAIL max_skip_last got=%0d/%0d exp=2/1062", SlotTypeOut, RingOut); end
        cyc(T_NULL, 32'd0, 4'd0);
        checks++; if ({SlotTypeOut, SourceOut, RingOut} !== {T_ADDR, 4'd3, 32'h1000_0200}) begin failures++; $display("FAIL max_append got=%0d/%0d/%h exp=2/3/10000200", SlotTypeOut, SourceOut, RingOut); end
        checks++; if (train_err !== 1'b0) begin failures++; $display("FAIL max_no_err got=%b exp=0", train_err); end
    endtask

    task automatic test_errors();
        logic [31:0] exp_d;
        do_reset();
        rif.req_addr  = 32'h1000_0100;
        rif.req_valid = 1'b1;
        cyc(T_TOKEN, 32'd0, 4'd0);
        checks++; if (train_err !== 1'b0) begin failures++; $display("FAIL err_before got=%b exp=0", train_err); end
        rif.req_valid = 1'b0;
        cyc(T_ADDR, 32'hDEAD, 4'd7);
        checks++; if ({SlotTypeOut, SourceOut, RingOut} !== {T_ADDR, 4'd3, 32'h1000_0100}) begin failures++; $display("FAIL err_discard got=%0d/%0d/%h exp=2/3/10000100", SlotTypeOut, SourceOut, RingOut); end
        checks++; if (train_err !== 1'b1) begin failures++; $display("FAIL err_append_set got=%b exp=1", train_err); end
        cyc(T_NULL, 32'd0, 4'd0);
        cyc(T_NULL, 32'd0, 4'd0);
        checks++; if (train_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", train_err); end
        do_reset();
        checks++; if (train_err !== 1'b0) begin failures++; $display("FAIL err_reset_clear got=%b exp=0", train_err); end
        // Underrun mid-burst: word 3 is emitted as 0 and not popped.
        for (int i = 0; i < 8; i++) push(32'hC0 + i);
        rif.req_addr  = 32'h0000_0080;
        rif.req_valid = 1'b1;
        cyc(T_TOKEN, 32'd0, 4'd0);
        rif.req_valid = 1'b0;
        cyc(T_NULL, 32'd0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            force_empty = (i == 3);
            cyc(T_NULL, 32'd0, 4'd0);
            exp_d = (i < 3) ? 32'hC0 + 32'(i) : (i == 3) ? 32'd0 : 32'hC0 + 32'(i) - 32'd1;
            checks++; if ({SlotTypeOut, RingOut} !== {T_WDATA, exp_d} || wd_rd_s !== (i != 3)) begin failures++; $display("FAIL err_underrun_w%0d got=%0d/%h wd_rd=%b exp=3/%h wd_rd=%b", i, SlotTypeOut, RingOut, wd_rd_s, exp_d, (i != 3)); end
        end
        force_empty = 1'b0;
        checks++; if (train_err !== 1'b1) begin failures++; $display("FAIL err_underrun_set got=%b exp=1", train_err); end
    endtask

    task automatic test_stats();
        do_reset();
        rif.req_addr  = 32'h1000_0300;
        rif.req_valid = 1'b1;
        cyc(T_TOKEN, 32'd0, 4'd0);
        rif.req_valid = 1'b0;
        cyc(T_NULL, 32'd0, 4'd0);
        cyc(T_TOKEN, 32'd0, 4'd0);
        rif.req_valid = 1'b1;
        cyc(T_TOKEN, 32'd0, 4'd0);
        rif.req_valid = 1'b0;
        cyc(T_NULL, 32'd0, 4'd0);
        cyc(T_TOKEN, 32'd0, 4'd0);
        cyc(T_TOKEN, 32'd0, 4'd0);
        checks++; if (tokens_seen !== 16'(EXP_TOK)) begin failures++; $display("FAIL stats_tokens got=%0d exp=%0d", tokens_seen, EXP_TOK); end
        checks++; if (reqs_sent !== 16'(EXP_REQS)) begin failures++; $display("FAIL stats_reqs got=%0d exp=%0d", reqs_sent, EXP_REQS); end
    endtask

    initial begin
        rif.req_valid = 1'b0;
        rif.req_addr  = 32'h0;
        @(negedge clock);
        test_reset();
        test_idle_passthrough();
        test_read_empty_train();
        test_write_behind_train();
        test_max_train();
        test_errors();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
